// File: rtl/amber48_pkg.sv
// amber48_pkg
// Shared types and constants for the amber48 execute stage.
//   md_op_e     : multiply/divide operation codes accepted by the sequencer
//   md_state_e  : sequencer FSM states
//   MD_XLEN     : datapath width of the amber48 core
//   MD_CYCLES   : number of iteration cycles spent in CALC (one bit per cycle)
//   md_is_div() : true for the divide-family operations
package amber48_pkg;

    localparam int MD_XLEN   = 48;
    localparam int MD_CYCLES = MD_XLEN;

    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // DIVU and REMU share the upper opcode bit.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/amber48_md_addsub.sv
// amber48_md_addsub
// Combinational add/subtract shared by the multiply and divide iterations.
//   sub_i : 1 = a_i - b_i, 0 = a_i + b_i
//   a_i   : first operand (W bits)
//   b_i   : second operand (W bits)
//   sum_o : result, W bits; for subtraction the MSB acts as the sign
module amber48_md_addsub #(
    parameter int W = 49
) (
    input  logic         sub_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    // Subtraction is a + ~b + 1, so one carry chain serves both modes.
    always_comb begin
        sum_o = a_i + (b_i ^ {W{sub_i}}) + W'(sub_i);
    end

endmodule

// File: rtl/amber48_muldiv_seq.sv
// amber48_muldiv_seq
// Bit-serial unsigned MUL/MULHU/DIVU/REMU sequencer for the amber48 execute
// stage. One request at a time; 48 iteration cycles over a single shared
// 49-bit add/subtract, then the result is held until the consumer takes it.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : request handshake (ready only in IDLE)
//   req_op_i, req_a_i, req_b_i, req_rd_i : operation, operands, dest tag
//   flush_i          : abort whatever is in flight, including a held result
//   resp_valid_o/resp_ready_i : response handshake
//   resp_result_o, resp_rd_o  : result and the tag captured at accept
//   busy_o           : high while an operation is in flight or held
module amber48_muldiv_seq
    import amber48_pkg::*;
#(
    parameter int XLEN  = 48,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    input  logic [TAG_W-1:0] req_rd_i,
    input  logic             flush_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_result_o,
    output logic [TAG_W-1:0] resp_rd_o,
    output logic             busy_o
);

    localparam logic [5:0] CNT_LOAD = 6'(MD_CYCLES - 1);

    md_state_e        state_q;
    md_op_e           op_q;
    logic [TAG_W-1:0] rd_q;
    logic [5:0]       cnt_q;
    // opnd_q holds the multiplicand A for multiplies and the divisor B for
    // divides, i.e. whatever the shared adder combines with hi_q each cycle.
    logic [XLEN-1:0]  opnd_q;
    // hi_q: product high half / partial remainder R.
    // lo_q: multiplier bits shifting out / quotient Q shifting in.
    // R never exceeds the divisor, so its 49th bit is always zero and is
    // not stored; the sign of the trial subtraction comes from the adder.
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  result_q;

    logic             add_sub;
    logic [XLEN:0]    add_a;
    logic [XLEN:0]    add_b;
    logic [XLEN:0]    add_sum;
    logic [XLEN:0]    div_shift;
    logic [XLEN-1:0]  hi_next;
    logic [XLEN-1:0]  lo_next;
    logic [XLEN-1:0]  final_result;
    logic             is_div;

    assign is_div = md_is_div(op_q);

    amber48_md_addsub #(.W(XLEN + 1)) u_addsub (
        .sub_i (add_sub),
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (add_sum)
    );

    // One iteration step. Multiply: conditionally add A to hi, then shift
    // {carry,hi,lo} right. Divide: shift the next dividend bit into R and
    // try subtracting B; a negative trial restores the shifted R and
    // shifts a 0 into Q.
    always_comb begin
        div_shift = {hi_q, lo_q[XLEN-1]};
        add_sub   = 1'b0;
        add_a     = {1'b0, hi_q};
        add_b     = lo_q[0] ? {1'b0, opnd_q} : '0;
        hi_next   = add_sum[XLEN:1];
        lo_next   = {add_sum[0], lo_q[XLEN-1:1]};
        if (is_div) begin
            add_sub = 1'b1;
            add_a   = div_shift;
            add_b   = {1'b0, opnd_q};
            if (add_sum[XLEN]) begin
                hi_next = div_shift[XLEN-1:0];
                lo_next = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                hi_next = add_sum[XLEN-1:0];
                lo_next = {lo_q[XLEN-2:0], 1'b1};
            end
        end
        // MULHU and REMU read the hi side, MUL and DIVU the lo side.
        final_result = op_q[0] ? hi_next : lo_next;
    end

    // Sequencer FSM. Flush wins over everything except reset, including a
    // response handshake in the same cycle. Result and tag are cleared when
    // the response leaves DONE so the outputs rest at their reset values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_MUL;
            rd_q     <= '0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (req_valid_i) begin
                        op_q  <= md_op_e'(req_op_i);
                        rd_q  <= req_rd_i;
                        hi_q  <= '0;
                        cnt_q <= CNT_LOAD;
                        if (md_is_div(req_op_i)) begin
                            opnd_q <= req_b_i;
                            lo_q   <= req_a_i;
                        end else begin
                            opnd_q <= req_a_i;
                            lo_q   <= req_b_i;
                        end
                        if (md_is_div(req_op_i) && (req_b_i == '0)) begin
                            // Divide by zero skips iteration entirely.
                            state_q  <= MD_DONE;
                            cnt_q    <= '0;
                            result_q <= (req_op_i == MD_DIVU) ? '1 : req_a_i;
                        end else begin
                            state_q <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    hi_q <= hi_next;
                    lo_q <= lo_next;
                    if (cnt_q == '0) begin
                        state_q  <= MD_DONE;
                        result_q <= final_result;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                MD_DONE: begin
                    if (resp_ready_i) begin
                        state_q  <= MD_IDLE;
                        rd_q     <= '0;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = (state_q == MD_IDLE);
    assign busy_o        = (state_q != MD_IDLE);
    assign resp_valid_o  = (state_q == MD_DONE);
    assign resp_result_o = result_q;
    assign resp_rd_o     = rd_q;

endmodule
